i2c_reg_access: RTL

//  Register-access sequencer sitting directly upstream of i2c_master; drives its control/data ports.

---
 rtl/i2c_reg_access.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_reg_access.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_reg_access
//  Description : Register-access sequencer in front of i2c_master. Turns one
//                register read/write command into complete I2C transactions
//                and reports completion, read data and NACK/timeout status.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_reg_access #(
    parameter int unsigned GAP_CYC     = 64,
    parameter int unsigned TIMEOUT_CYC = 2097151
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_read,
    input  logic        cmd_two_byte,
    input  logic [6:0]  cmd_dev_addr,
    input  logic [7:0]  cmd_reg_addr,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic        rsp_nack,
    output logic        rsp_timeout,
    output logic [15:0] rsp_rdata,
    output logic        m_start,
    output logic        m_read_nwrite,
    output logic [6:0]  m_addr,
    output logic [1:0]  m_byte_size,
    output logic [7:0]  m_data_i,
    output logic        m_data_valid,
    input  logic        m_busy,
    input  logic        m_new_data,
    input  logic [7:0]  m_data_o,
    input  logic        m_scl
);

    localparam logic [20:0] c_TIMEOUT  = 21'(TIMEOUT_CYC);
    localparam logic [20:0] c_GAP_LAST = 21'(GAP_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_XFER   = 3'd2,
        S_GAP    = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    state_t      r_state;
    logic [1:0]  r_busy_sync, r_nd_sync, r_scl_sync;
    logic        r_busy_d, r_nd_d, r_scl_d;
    logic        r_read, r_two, r_phase2;
    logic [7:0]  r_reg;
    logic [15:0] r_wdata;
    logic [20:0] r_cnt;
    logic [3:0]  r_bit_cnt, r_frames;
    logic        r_start_seen;

    logic        w_busy_s, w_busy_fall, w_nd_fall, w_scl_fall;
    logic [3:0]  w_list_len, w_expect;
    logic [7:0]  w_list_byte;
    logic        w_list_has, w_to_hit, w_track;
    logic [20:0] w_cnt_next;

    // Synchronisers keep tracking the master through rst, which does not stop the bus
    always_ff @(posedge clk) begin
        r_busy_sync <= {r_busy_sync[0], m_busy};
        r_nd_sync   <= {r_nd_sync[0], m_new_data};
        r_scl_sync  <= {r_scl_sync[0], m_scl};
        r_busy_d    <= r_busy_sync[1];
        r_nd_d      <= r_nd_sync[1];
        r_scl_d     <= r_scl_sync[1];
    end

    assign w_busy_s    = r_busy_sync[1];
    assign w_busy_fall = r_busy_d & ~w_busy_s;
    assign w_nd_fall   = r_nd_d & ~r_nd_sync[1];
    assign w_scl_fall  = r_scl_d & ~r_scl_sync[1];
    assign cmd_ready   = (r_state == S_IDLE) & ~w_busy_s;
    assign w_cnt_next  = r_cnt + 21'd1;
    assign w_to_hit    = (w_cnt_next == c_TIMEOUT);
    assign w_track     = (r_state == S_LAUNCH) || (r_state == S_XFER);

    // Byte list of the current transaction: [reg, (wdata[15:8]), wdata[7:0]] for writes,
    // [reg] for the pointer phase of a read, nothing for the read phase.
    always_comb begin
        w_list_len  = 4'd0;
        w_list_byte = 8'h00;
        if (!r_phase2) begin
            if (r_read) w_list_len = 4'd1;
            else        w_list_len = r_two ? 4'd3 : 4'd2;
        end
        case (r_frames)
            4'd0:    w_list_byte = r_reg;
            4'd1:    w_list_byte = r_two ? r_wdata[15:8] : r_wdata[7:0];
            4'd2:    w_list_byte = r_wdata[7:0];
            default: w_list_byte = 8'h00;
        endcase
    end

    assign w_list_has = (r_frames < w_list_len);
    assign w_expect   = r_phase2 ? (4'd2 + {3'b000, r_two}) : (w_list_len + 4'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_read        <= 1'b0;
            r_two         <= 1'b0;
            r_phase2      <= 1'b0;
            r_reg         <= 8'h00;
            r_wdata       <= 16'h0000;
            r_cnt         <= 21'd0;
            r_bit_cnt     <= 4'd0;
            r_frames      <= 4'd0;
            r_start_seen  <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_nack      <= 1'b0;
            rsp_timeout   <= 1'b0;
            rsp_rdata     <= 16'h0000;
            m_start       <= 1'b0;
            m_read_nwrite <= 1'b0;
            m_addr        <= 7'h00;
            m_byte_size   <= 2'd0;
            m_data_i      <= 8'h00;
            m_data_valid  <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;

            // The first SCL fall is the start condition; then 9 falls per frame
            if (w_track && w_scl_fall) begin
                if (!r_start_seen) begin
                    r_start_seen <= 1'b1;
                end else if (r_bit_cnt == 4'd8) begin
                    r_bit_cnt <= 4'd0;
                    if (r_frames != 4'hF) r_frames <= r_frames + 4'd1;
                end else begin
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                    if (r_bit_cnt == 4'd3) begin
                        m_data_i     <= w_list_has ? w_list_byte : 8'h00;
                        m_data_valid <= w_list_has;
                    end
                end
            end

            if (r_state == S_XFER && w_nd_fall)
                rsp_rdata <= {rsp_rdata[7:0], m_data_o};

            case (r_state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        r_read        <= cmd_read;
                        r_two         <= cmd_two_byte;
                        r_reg         <= cmd_reg_addr;
                        r_wdata       <= cmd_wdata;
                        r_phase2      <= 1'b0;
                        m_addr        <= cmd_dev_addr;
                        m_read_nwrite <= 1'b0;
                        m_byte_size   <= cmd_read ? 2'd0 : (cmd_two_byte ? 2'd2 : 2'd1);
                        rsp_nack      <= 1'b0;
                        rsp_timeout   <= 1'b0;
                        rsp_rdata     <= 16'h0000;
                        m_start       <= 1'b1;
                        m_data_i      <= 8'h00;
                        m_data_valid  <= 1'b0;
                        r_cnt         <= 21'd0;
                        r_bit_cnt     <= 4'd0;
                        r_frames      <= 4'd0;
                        r_start_seen  <= 1'b0;
                        r_state       <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    r_cnt <= w_cnt_next;
                    if (w_to_hit) begin
                        m_start     <= 1'b0;
                        rsp_timeout <= 1'b1;
                        rsp_valid   <= 1'b1;
                        r_state     <= S_RESP;
                    end else if (w_busy_s) begin
                        m_start <= 1'b0;
                        r_state <= S_XFER;
                    end
                end
                S_XFER: begin
                    r_cnt <= w_cnt_next;
                    // A busy fall in the same cycle as expiry reports the bus result
                    if (w_busy_fall) begin
                        m_data_valid <= 1'b0;
                        if (r_frames < w_expect) begin
                            rsp_nack  <= 1'b1;
                            rsp_valid <= 1'b1;
                            r_state   <= S_RESP;
                        end else if (r_read && !r_phase2) begin
                            r_cnt   <= 21'd0;
                            r_state <= S_GAP;
                        end else begin
                            rsp_valid <= 1'b1;
                            r_state   <= S_RESP;
                        end
                    end else if (w_to_hit) begin
                        m_data_valid <= 1'b0;
                        rsp_timeout  <= 1'b1;
                        rsp_valid    <= 1'b1;
                        r_state      <= S_RESP;
                    end
                end
                S_GAP: begin
                    if (r_cnt == c_GAP_LAST) begin
                        r_phase2      <= 1'b1;
                        m_read_nwrite <= 1'b1;
                        m_byte_size   <= {1'b0, r_two};
                        m_start       <= 1'b1;
                        m_data_i      <= 8'h00;
                        m_data_valid  <= 1'b0;
                        r_cnt         <= 21'd0;
                        r_bit_cnt     <= 4'd0;
                        r_frames      <= 4'd0;
                        r_start_seen  <= 1'b0;
                        r_state       <= S_LAUNCH;
                    end else begin
                        r_cnt <= w_cnt_next;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
